// File: rtl/adc_spi_cfg_ctrl.sv
// Avalon-MM configured sequencer for single-byte ADC transactions over 3-wire SPI.
// Optional read-back path enabled by defining ADC_SPI_READBACK_EN.
module adc_spi_cfg_ctrl #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic       main_clk,
    input  logic       reset_n,
    input  logic [3:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       ADC_CSBn,
    output logic       ADC_SCLK,
    output logic       sdio_out,
    output logic       sdio_oe,
    input  logic       sdio_in,
    output logic       cfg_done
);

    localparam int unsigned DIV_W        = 8;
    localparam int unsigned CNT_W        = 6;
    localparam int unsigned FRAME_W      = 24;
    localparam int unsigned SHIFT_HALVES = 48;
    localparam int unsigned OE_DROP_K    = 31;
    localparam int unsigned RX_FIRST_K   = 32;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t               r_state, w_state_nx;
    logic [DIV_W-1:0]     r_div, w_div_nx;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
    logic [FRAME_W-1:0]   r_shift, w_shift_nx;
    logic [7:0]           r_rx, w_rx_nx;
    logic                 r_rnw, w_rnw_nx;
    logic                 r_csbn, w_csbn_nx;
    logic                 r_sclk, w_sclk_nx;
    logic                 r_sdo, w_sdo_nx;
    logic                 r_oe, w_oe_nx;
    logic                 r_done_pulse, w_done_pulse_nx;

    logic [7:0]           r_addr_lo;
    logic [4:0]           r_addr_hi;
    logic [7:0]           r_wdata;
    logic [7:0]           r_rdata;
    logic                 r_done;
    logic                 r_ovr;
    logic [7:0]           r_readdata;
    logic [7:0]           w_rd_mux;

    logic                 w_start;
    logic                 w_busy;
    logic                 w_tick;
    logic                 w_frame_end;
    logic                 w_rnw_req;
    logic [FRAME_W-1:0]   w_frame;

`ifdef ADC_SPI_READBACK_EN
    assign w_rnw_req = writedata[1];
`else
    assign w_rnw_req = 1'b0;
`endif

    assign w_start     = write && (address == 4'd3) && writedata[0];
    assign w_busy      = (r_state != S_IDLE);
    assign w_tick      = (r_div == DIV_LAST);
    assign w_frame_end = (r_state == S_GAP) && w_tick && (r_cnt == CNT_W'(1));
    // Read frames send zeros in the data byte; the slave owns SDIO for that part.
    assign w_frame     = {w_rnw_req, 2'b00, r_addr_hi, r_addr_lo,
                          (w_rnw_req ? 8'h00 : r_wdata)};

    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_rx         <= '0;
            r_rnw        <= 1'b0;
            r_csbn       <= 1'b1;
            r_sclk       <= 1'b0;
            r_sdo        <= 1'b0;
            r_oe         <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_div        <= w_div_nx;
            r_cnt        <= w_cnt_nx;
            r_shift      <= w_shift_nx;
            r_rx         <= w_rx_nx;
            r_rnw        <= w_rnw_nx;
            r_csbn       <= w_csbn_nx;
            r_sclk       <= w_sclk_nx;
            r_sdo        <= w_sdo_nx;
            r_oe         <= w_oe_nx;
            r_done_pulse <= w_done_pulse_nx;
        end
    end

    // Frame sequencer: every step advances on the last cycle of a half-period.
    always_comb begin
        w_state_nx      = r_state;
        w_div_nx        = w_tick ? '0 : r_div + DIV_W'(1);
        w_cnt_nx        = r_cnt;
        w_shift_nx      = r_shift;
        w_rx_nx         = r_rx;
        w_rnw_nx        = r_rnw;
        w_csbn_nx       = r_csbn;
        w_sclk_nx       = r_sclk;
        w_sdo_nx        = r_sdo;
        w_oe_nx         = r_oe;
        w_done_pulse_nx = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_div_nx = '0;
                if (w_start) begin
                    w_state_nx = S_SETUP;
                    w_cnt_nx   = '0;
                    w_shift_nx = w_frame;
                    w_rnw_nx   = w_rnw_req;
                    w_csbn_nx  = 1'b0;
                    w_sclk_nx  = 1'b0;
                    w_sdo_nx   = w_frame[FRAME_W-1];
                    w_oe_nx    = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    w_state_nx = S_SHIFT;
                    w_cnt_nx   = '0;
                    w_sclk_nx  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_tick) begin
                    if (r_cnt == CNT_W'(SHIFT_HALVES - 1)) begin
                        w_state_nx = S_HOLD;
                        w_cnt_nx   = '0;
                        w_sclk_nx  = 1'b0;
                    end else begin
                        w_cnt_nx  = r_cnt + CNT_W'(1);
                        w_sclk_nx = ~r_sclk;
                        if (r_sclk) begin
                            // Falling edge: present the next bit, hand SDIO over on reads.
                            if (r_cnt < CNT_W'(SHIFT_HALVES - 3)) begin
                                w_shift_nx = {r_shift[FRAME_W-2:0], 1'b0};
                                w_sdo_nx   = r_shift[FRAME_W-2];
                            end
                            if (r_rnw && (r_cnt == CNT_W'(OE_DROP_K - 1))) begin
                                w_oe_nx = 1'b0;
                            end
                        end else if (r_cnt >= CNT_W'(RX_FIRST_K - 1)) begin
                            w_rx_nx = {r_rx[6:0], sdio_in};
                        end
                    end
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    w_state_nx = S_GAP;
                    w_cnt_nx   = '0;
                    w_csbn_nx  = 1'b1;
                    w_oe_nx    = 1'b0;
                    w_sdo_nx   = 1'b0;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    if (w_frame_end) begin
                        w_state_nx      = S_IDLE;
                        w_done_pulse_nx = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_mux = 8'h00;
        case (address)
            4'd0:    w_rd_mux = r_addr_lo;
            4'd1:    w_rd_mux = {3'b000, r_addr_hi};
            4'd2:    w_rd_mux = r_wdata;
            4'd4:    w_rd_mux = {5'b00000, r_ovr, r_done, w_busy};
            4'd5:    w_rd_mux = r_rdata;
            default: w_rd_mux = 8'h00;
        endcase
    end

    // Register file; end-of-frame sets come last so they win over a same-cycle clear.
    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr_lo  <= '0;
            r_addr_hi  <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (write) begin
                case (address)
                    4'd0: r_addr_lo <= writedata;
                    4'd1: r_addr_hi <= writedata[4:0];
                    4'd2: r_wdata   <= writedata;
                    4'd4: begin
                        if (writedata[1]) r_done <= 1'b0;
                        if (writedata[2]) r_ovr  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (w_start && w_busy) begin
                r_ovr <= 1'b1;
            end
            if (w_frame_end) begin
                r_done <= 1'b1;
                if (r_rnw) begin
                    r_rdata <= r_rx;
                end
            end
            if (read) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign readdata = r_readdata;
    assign ADC_CSBn = r_csbn;
    assign ADC_SCLK = r_sclk;
    assign sdio_out = r_sdo;
    assign sdio_oe  = r_oe;
    assign cfg_done = r_done_pulse;

endmodule

// File: tb/tb_adc_spi_cfg_ctrl.sv
// Self-checking bench for adc_spi_cfg_ctrl: SPI monitor + slave, randomized frames
// checked against a frame-level reference model.
module tb_adc_spi_cfg_ctrl;

    localparam int unsigned H = 4;
`ifdef ADC_SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       main_clk  = 1'b0;
    logic       reset_n   = 1'b1;
    logic [3:0] address   = 4'd0;
    logic       read      = 1'b0;
    logic       write     = 1'b0;
    logic [7:0] writedata = 8'h00;
    logic [7:0] readdata;
    logic       ADC_CSBn;
    logic       ADC_SCLK;
    logic       sdio_out;
    logic       sdio_oe;
    logic       sdio_in   = 1'b0;
    logic       cfg_done;

    int errors = 0;
    int checks = 0;

    // Monitor / slave state
    logic        prev_csbn  = 1'b1;
    logic        prev_sclk  = 1'b0;
    int          mon_cnt    = 0;
    int          fall_cnt   = 0;
    int          rise_total = 0;
    int          done_cnt   = 0;
    int          oe_bad     = 0;
    logic [23:0] mon_word   = 24'h0;
    logic [7:0]  slave_byte = 8'h00;
    logic        cur_rnw    = 1'b0;
    logic [7:0]  exp_rdata  = 8'h00;

    adc_spi_cfg_ctrl #(.CLK_DIV(H)) dut (
        .main_clk (main_clk),
        .reset_n  (reset_n),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .ADC_CSBn (ADC_CSBn),
        .ADC_SCLK (ADC_SCLK),
        .sdio_out (sdio_out),
        .sdio_oe  (sdio_oe),
        .sdio_in  (sdio_in),
        .cfg_done (cfg_done)
    );

    always #5 main_clk = ~main_clk;

    // Pin-level SPI monitor and ADC slave model
    always @(negedge main_clk) begin
        if (prev_csbn && !ADC_CSBn) begin
            mon_cnt  = 0;
            fall_cnt = 0;
            mon_word = 24'h0;
        end
        if (!prev_sclk && ADC_SCLK) begin
            rise_total++;
            if (!ADC_CSBn) begin
                mon_word = {mon_word[22:0], sdio_out};
                mon_cnt++;
            end
        end
        if (prev_sclk && !ADC_SCLK && !ADC_CSBn) begin
            fall_cnt++;
            if (fall_cnt >= 16 && fall_cnt < 24) sdio_in = slave_byte[23 - fall_cnt];
            else sdio_in = 1'($urandom);
        end
        if (ADC_CSBn) begin
            if (sdio_oe !== 1'b0) oe_bad++;
        end else if (sdio_oe !== !(cur_rnw && fall_cnt >= 16)) begin
            oe_bad++;
        end
        if (cfg_done === 1'b1) done_cnt++;
        prev_csbn = ADC_CSBn;
        prev_sclk = ADC_SCLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge main_clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge main_clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge main_clk);
        address = a; read = 1'b1;
        @(negedge main_clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic run_frame(input logic [12:0] a, input logic [7:0] d, input logic rnw,
                             input logic [7:0] sbyte, input int inject_at, input string tag);
        logic [23:0] exp_word;
        logic        rnw_eff;
        logic        ovr;
        logic        got;
        logic [7:0]  rv;
        logic [7:0]  exp_st;
        int          n;
        int          d0;
        int          oe0;
        rnw_eff  = rnw & RB;
        ovr      = (inject_at > 0);
        exp_word = {rnw_eff, 2'b00, a, (rnw_eff ? 8'h00 : d)};
        bus_write(4'd0, a[7:0]);
        bus_write(4'd1, {3'b000, a[12:8]});
        bus_write(4'd2, d);
        slave_byte = sbyte;
        cur_rnw    = rnw_eff;
        d0  = done_cnt;
        oe0 = oe_bad;
        bus_write(4'd3, {6'b000000, rnw, 1'b1});
        n   = 1;
        got = 1'b0;
        while (!got && n < 400) begin
            if (cfg_done === 1'b1) got = 1'b1;
            else begin
                if (n == inject_at) begin
                    address = 4'd3; writedata = 8'h01; write = 1'b1;
                end else begin
                    write = 1'b0;
                end
                @(negedge main_clk);
                n++;
            end
        end
        write = 1'b0;
        checks++;
        if (!got || (n - 1) != int'(52 * H)) begin
            errors++;
            $display("FAIL %s busy_len: got %0d (done seen %0b) required %0d", tag, n - 1, got, 52 * H);
        end
        @(negedge main_clk);
        checks++;
        if (cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: cfg_done=%b required 0", tag, cfg_done);
        end
        checks++;
        if (mon_cnt != 24) begin
            errors++;
            $display("FAIL %s rise_count: got %0d required 24", tag, mon_cnt);
        end
        checks++;
        if (mon_word !== exp_word) begin
            errors++;
            $display("FAIL %s frame_word: got %06h required %06h", tag, mon_word, exp_word);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d required 1", tag, done_cnt - d0);
        end
        checks++;
        if (oe_bad != oe0) begin
            errors++;
            $display("FAIL %s sdio_oe_rule: got %0d bad cycles required 0", tag, oe_bad - oe0);
        end
        if (rnw_eff) exp_rdata = sbyte;
        exp_st = {5'b00000, ovr, 1'b1, 1'b0};
        bus_read(4'd4, rv);
        checks++;
        if (rv !== exp_st) begin
            errors++;
            $display("FAIL %s status: got %02h required %02h", tag, rv, exp_st);
        end
        bus_read(4'd5, rv);
        checks++;
        if (rv !== exp_rdata) begin
            errors++;
            $display("FAIL %s rdata: got %02h required %02h", tag, rv, exp_rdata);
        end
        bus_write(4'd4, 8'h06);
        bus_read(4'd4, rv);
        checks++;
        if (rv !== 8'h00) begin
            errors++;
            $display("FAIL %s status_clear: got %02h required 00", tag, rv);
        end
    endtask

    task automatic test_reset();
        logic [7:0] rv;
        #2 reset_n = 1'b0;
        #3;
        checks++;
        if (ADC_CSBn !== 1'b1 || ADC_SCLK !== 1'b0 || sdio_oe !== 1'b0 || sdio_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_pins: csbn=%b sclk=%b oe=%b sdo=%b required 1 0 0 0",
                     ADC_CSBn, ADC_SCLK, sdio_oe, sdio_out);
        end
        checks++;
        if (readdata !== 8'h00 || cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: readdata=%02h cfg_done=%b required 00 0", readdata, cfg_done);
        end
        repeat (3) @(negedge main_clk);
        reset_n = 1'b1;
        bus_read(4'd4, rv);
        checks++;
        if (rv !== 8'h00) begin
            errors++;
            $display("FAIL reset_status: got %02h required 00", rv);
        end
    endtask

    task automatic test_regs();
        logic [7:0] rv;
        bus_write(4'd1, 8'hFF);
        bus_read(4'd1, rv);
        checks++;
        if (rv !== 8'h1F) begin errors++; $display("FAIL addr_hi_mask: got %02h required 1f", rv); end
        bus_write(4'd0, 8'h5A);
        bus_read(4'd0, rv);
        checks++;
        if (rv !== 8'h5A) begin errors++; $display("FAIL addr_lo: got %02h required 5a", rv); end
        bus_write(4'd2, 8'hC3);
        bus_read(4'd2, rv);
        checks++;
        if (rv !== 8'hC3) begin errors++; $display("FAIL wdata: got %02h required c3", rv); end
        bus_read(4'd3, rv);
        checks++;
        if (rv !== 8'h00) begin errors++; $display("FAIL ctrl_read: got %02h required 00", rv); end
        bus_write(4'd9, 8'h77);
        bus_read(4'd9, rv);
        checks++;
        if (rv !== 8'h00) begin errors++; $display("FAIL unmapped_9: got %02h required 00", rv); end
        bus_read(4'd5, rv);
        checks++;
        if (rv !== exp_rdata) begin errors++; $display("FAIL rdata_reset: got %02h required %02h", rv, exp_rdata); end
    endtask

    task automatic test_write_frame();
        run_frame(13'h0014, 8'hA5, 1'b0, 8'h00, -1, "write");
    endtask

    task automatic test_read_frame();
        run_frame(13'h0001, 8'h5E, 1'b1, 8'h3C, -1, "read");
    endtask

    task automatic test_overrun();
        run_frame(13'h0A7F, 8'h3C, 1'b0, 8'h00, 50, "overrun");
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int r0;
        int r1;
        bus_write(4'd0, 8'h33);
        bus_write(4'd1, 8'h02);
        bus_write(4'd2, 8'h99);
        cur_rnw = 1'b0;
        r0 = rise_total;
        bus_write(4'd3, 8'h01);
        n = 0;
        while ((rise_total - r0) < 10 && n < 600) begin
            @(negedge main_clk);
            #1;
            n++;
        end
        checks++;
        if ((rise_total - r0) != 10) begin
            errors++;
            $display("FAIL midrst_reach: got %0d rises required 10", rise_total - r0);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ADC_CSBn !== 1'b1 || ADC_SCLK !== 1'b0 || sdio_oe !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pins: csbn=%b sclk=%b oe=%b required 1 0 0", ADC_CSBn, ADC_SCLK, sdio_oe);
        end
        r1 = rise_total;
        repeat (40) @(negedge main_clk);
        checks++;
        if (rise_total != r1 || ADC_CSBn !== 1'b1) begin
            errors++;
            $display("FAIL midrst_quiet: extra rises %0d csbn=%b required 0 1", rise_total - r1, ADC_CSBn);
        end
        reset_n = 1'b1;
        exp_rdata = 8'h00;
        run_frame(13'h1234, 8'h81, 1'b0, 8'h00, -1, "post_reset");
    endtask

    task automatic test_random();
        logic [12:0] a;
        logic [7:0]  d;
        logic [7:0]  sb;
        logic        rnw;
        int          inj;
        for (int i = 0; i < 8; i++) begin
            a   = 13'($urandom);
            d   = 8'($urandom);
            sb  = 8'($urandom);
            rnw = 1'($urandom);
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 200)) : -1;
            run_frame(a, d, rnw, sb, inj, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_write_frame();
        test_read_frame();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
